word_hold_buffer: RTL

//  Parametrised elastic holding buffer for compressor Stage3 words.

---
 rtl/word_hold_buffer.sv | 83 ++++++++
 1 files changed

// File: rtl/word_hold_buffer.sv
// Elastic first-word-fall-through holding buffer for Stage3 words.
// When empty, o_word keeps showing the most recently popped word.
module word_hold_buffer #(
  parameter  int unsigned WIDTH = 128,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_word,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hold_q;

  logic push;
  logic pop;
  logic full;
  logic empty;

  // Status is decoded from the registered count only, never from inputs.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = i_valid & ~full;
    pop   = i_ready & ~empty;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hold_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Flush leaves hold_q alone so the last popped word stays visible.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    o_ready = ~full;
    o_valid = ~empty;
    o_full  = full;
    o_empty = empty;
    o_count = count_q;
    o_word  = empty ? hold_q : mem[rd_ptr];
  end

endmodule
